// File: rtl/uart_rx_fifo.sv
// UART receiver with two-flop rx synchroniser, start-bit glitch rejection, parity/framing
// checks and a first-word fall-through receive FIFO that drives an active-low cts.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 13,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rts,
    output logic                          cts,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          par_err,
    output logic                          frm_err,
    output logic                          data_valid,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int ENT_W = DATA_BITS + 2;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] PUSH   = 3'd5;

    localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    logic                 rx_p0;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        clock_div;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] sh;
    logic                 perr;
    logic                 ferr;

    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt;
    logic [ENT_W-1:0]     head;
    logic                 push_req;
    logic                 pop;
    logic                 wr_ok;
    logic                 bit_end;

    // ---- stage p0/s: rx synchroniser, idles high out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    assign bit_end = (clock_div == BIT_LAST);

    // ---- frame FSM; rts is only honoured in IDLE, so an active frame always completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            clock_div <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s && !rts) begin
                        state     <= START;
                        clock_div <= '0;
                    end
                end
                START: begin
                    if (clock_div == HALF_LAST) begin
                        clock_div <= '0;
                        bit_cnt   <= '0;
                        state     <= rx_s ? IDLE : DATA;
                    end else begin
                        clock_div <= clock_div + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clock_div <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clock_div <= clock_div + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        clock_div <= '0;
                        bit_cnt   <= '0;
                        state     <= STOP;
                    end else begin
                        clock_div <= clock_div + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clock_div <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= PUSH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clock_div <= clock_div + 1'b1;
                    end
                end
                PUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    clock_div <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

    // ---- frame datapath: shift register and error flags, cleared when a start bit is confirmed
    always_ff @(posedge clk) begin
        if (state == START && clock_div == HALF_LAST) begin
            perr <= 1'b0;
            ferr <= 1'b0;
        end
        if (state == DATA && bit_end) begin
            sh <= {rx_s, sh[DATA_BITS-1:1]};
        end
        if (state == PARITY && bit_end) begin
            perr <= (^{sh, rx_s}) ^ PAR_ODD;
        end
        if (state == STOP && bit_end && !rx_s) begin
            ferr <= 1'b1;
        end
    end

    assign push_req = (state == PUSH);
    assign pop      = rd_en && (count != '0);
    // A full FIFO still takes the word when the consumer pops in the same cycle.
    assign wr_ok    = push_req && ((count != DEPTH_C) || rd_en);

    always_comb begin
        count_nxt = count;
        if (wr_ok) begin
            count_nxt = count_nxt + CNT_W'(1);
        end
        if (pop) begin
            count_nxt = count_nxt - CNT_W'(1);
        end
    end

    // ---- FIFO control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cts     <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            cts     <= (count_nxt == DEPTH_C);
            overrun <= push_req && !wr_ok;
        end
    end

    // ---- FIFO storage
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {ferr, perr, sh};
        end
    end

    assign head       = mem[rd_ptr];
    assign data_valid = (count != '0);
    assign fifo_count = count;
    assign data_out   = data_valid ? head[DATA_BITS-1:0] : '0;
    assign par_err    = data_valid & head[DATA_BITS];
    assign frm_err    = data_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance on separate rx lines.
module tb_uart_rx_fifo;

    localparam int C = 13;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1;
    logic       rts;
    logic       rd_en0, rd_en1;

    logic       cts0, cts1;
    logic [7:0] dout0, dout1;
    logic       perr0, perr1, ferr0, ferr1;
    logic       dv0, dv1, ovr0, ovr1;
    logic [2:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;
    int ovr_pulses = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rts(rts), .cts(cts0), .rd_en(rd_en0),
        .data_out(dout0), .par_err(perr0), .frm_err(ferr0), .data_valid(dv0),
        .overrun(ovr0), .fifo_count(cnt0)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rts(rts), .cts(cts1), .rd_en(rd_en1),
        .data_out(dout1), .par_err(perr1), .frm_err(ferr1), .data_valid(dv1),
        .overrun(ovr1), .fifo_count(cnt1)
    );

    always @(posedge clk) begin
        if (ovr0) ovr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int sel, input logic v);
        if (sel != 0) rx1 = v;
        else          rx0 = v;
        tick(C);
    endtask

    // Start bit, 8 data bits LSB first, optional parity, one stop bit, then idle.
    // pop_at_push raises rd_en0 for exactly the cycle in which the frame is written.
    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop, input bit pop_at_push);
        int push_edge;
        push_edge = 2 + C / 2 + (8 + int'(has_par) + 1) * C;
        fork
            begin
                drive_bit(sel, 1'b0);
                for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
                if (has_par) drive_bit(sel, par);
                drive_bit(sel, stop);
            end
            begin
                if (pop_at_push) begin
                    repeat (push_edge + 1) @(posedge clk);
                    #1;
                    rd_en0 = 1'b1;
                    @(posedge clk);
                    #1;
                    rd_en0 = 1'b0;
                end
            end
        join
        if (sel != 0) rx1 = 1'b1;
        else          rx0 = 1'b1;
        tick(3);
    endtask

    task automatic pop0();
        rd_en0 = 1'b1;
        tick(1);
        rd_en0 = 1'b0;
    endtask

    task automatic pop1();
        rd_en1 = 1'b1;
        tick(1);
        rd_en1 = 1'b0;
    endtask

    initial begin
        int base;
        logic [7:0] exp_d;
        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rts = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0;
        tick(3);
        check("rst_cts", cts0, 1);
        check("rst_valid", dv0, 0);
        check("rst_count", cnt0, 0);
        check("rst_dout", dout0, 0);
        check("rst_ovr", ovr0, 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_cts", cts0, 0);

        // 0xA5 8N1
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 0);
        check("a5_valid", dv0, 1);
        check("a5_data", dout0, 8'hA5);
        check("a5_perr", perr0, 0);
        check("a5_ferr", ferr0, 0);
        check("a5_count", cnt0, 1);
        pop0();
        check("a5_pop_count", cnt0, 0);
        check("a5_pop_valid", dv0, 0);

        // start glitch of 3 cycles
        rx0 = 1'b0;
        tick(3);
        rx0 = 1'b1;
        tick(2 * C);
        check("glitch_valid", dv0, 0);
        check("glitch_count", cnt0, 0);
        send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 0);
        check("after_glitch_data", dout0, 8'hC3);
        pop0();

        // rts deasserted in IDLE blocks reception
        rts = 1'b1;
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, 0);
        check("rts_blocked_count", cnt0, 0);
        rts = 1'b0;
        tick(2);

        // framing error
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 0);
        check("frm_data", dout0, 8'h3C);
        check("frm_err", ferr0, 1);
        check("frm_perr", perr0, 0);
        check("frm_count", cnt0, 1);
        pop0();

        // even parity instance
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 0);
        check("par_ok_data", dout1, 8'h07);
        check("par_ok_perr", perr1, 0);
        check("par_ok_ferr", ferr1, 0);
        pop1();
        send_frame(1, 8'h07, 1, 1'b0, 1'b1, 0);
        check("par_bad_data", dout1, 8'h07);
        check("par_bad_perr", perr1, 1);
        pop1();
        check("par_empty", dv1, 0);

        // fill to full, then overrun
        for (int i = 1; i <= 4; i++) begin
            send_frame(0, 8'(i), 0, 1'b0, 1'b1, 0);
            check("fill_count", cnt0, 32'(i));
        end
        check("full_cts", cts0, 1);
        base = ovr_pulses;
        send_frame(0, 8'h05, 0, 1'b0, 1'b1, 0);
        check("ovr_pulse", 32'(ovr_pulses - base), 1);
        check("ovr_count", cnt0, 4);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_read", dout0, 32'(i));
            pop0();
        end
        check("drained_valid", dv0, 0);
        check("drained_cts", cts0, 0);

        // full, but consumer pops in the push cycle
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 0, 1'b0, 1'b1, 0);
        base = ovr_pulses;
        send_frame(0, 8'h05, 0, 1'b0, 1'b1, 1);
        check("pop_push_no_ovr", 32'(ovr_pulses - base), 0);
        check("pop_push_count", cnt0, 4);
        for (int i = 2; i <= 5; i++) begin
            check("pop_push_read", dout0, 32'(i));
            pop0();
        end
        check("pop_push_empty", cnt0, 0);

        // reset mid-DATA with two entries queued
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 0);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, 0);
        check("pre_rst_count", cnt0, 2);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("midrst_count", cnt0, 0);
        check("midrst_valid", dv0, 0);
        check("midrst_dout", dout0, 0);
        check("midrst_cts", cts0, 1);
        check("midrst_perr", perr0, 0);
        check("midrst_ferr", ferr0, 0);
        check("midrst_ovr", ovr0, 0);
        rst_n = 1'b1;
        rx0 = 1'b1;
        tick(2 * C);
        check("post_rst_count", cnt0, 0);
        exp_d = 8'h5A;
        send_frame(0, exp_d, 0, 1'b0, 1'b1, 0);
        check("post_rst_data", dout0, 32'(exp_d));
        check("post_rst_count1", cnt0, 1);
        check("post_rst_ferr", ferr0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
